// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, default sizing and width helper for data_mem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_WORDS = 256;
  localparam int DEF_READ_LATENCY = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: one-entry posted store buffer with load-forwarding compare
module dmem_write_buffer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_store,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_data,
  output logic          o_hit,
  output logic [31:0]   o_hit_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_idx,
  output logic [31:0]   o_wr_data
);
  logic          r_valid;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_store;
      if (i_store) begin
        r_idx  <= i_idx;
        r_data <= i_data;
      end
    end
  assign o_hit      = r_valid & (r_idx == i_idx);
  assign o_hit_data = r_data;
  // A valid entry always leaves this cycle: displaced by a new store or drained when idle
  assign o_wr_en    = r_valid;
  assign o_wr_idx   = r_idx;
  assign o_wr_data  = r_data;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word data memory with multi-cycle loads and stall back-pressure
// Define DMEM_WRITE_BUFFER_EN to post stores through a one-entry forwarding write buffer
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WORDS        = DEF_WORDS,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        err
);
  localparam int AW = clog2(WORDS);
  localparam int CW = clog2(READ_LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mem [WORDS];
  logic [AW-1:0] w_idx;
  logic          w_store;
  logic          w_bad;
  logic          w_unused;
  logic [31:0]   w_rd_data;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;
  assign w_idx    = addr[AW+1:2];
  assign w_unused = ^addr[31:AW+2];
  assign w_store  = mem_write & ~mem_read;
  assign w_bad    = (mem_read & mem_write) | ((mem_read | mem_write) & (addr[1:0] != 2'b00));
  // Gated by reset so stall reads low while the core is held in reset
  assign stall    = reset & mem_read & (r_state != RESP);
  always_comb
    w_next = (r_state == RESP) ? IDLE :
             (r_state == WAIT) ? ((r_cnt == '0) ? RESP : WAIT) :
             (mem_read ? ((READ_LATENCY == 1) ? RESP : WAIT) : IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      load_data <= '0;
      err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT) ? r_cnt - 1'b1 : CNT_INIT;
      if (w_next == RESP) load_data <= w_rd_data;
      err <= err | w_bad;
    end
`ifdef DMEM_WRITE_BUFFER_EN
  logic        w_hit;
  logic [31:0] w_hit_data;
  dmem_write_buffer #(.AW(AW)) u_wb (
    .clk        (clk),
    .reset      (reset),
    .i_store    (w_store),
    .i_idx      (w_idx),
    .i_data     (store_data),
    .o_hit      (w_hit),
    .o_hit_data (w_hit_data),
    .o_wr_en    (w_wr_en),
    .o_wr_idx   (w_wr_idx),
    .o_wr_data  (w_wr_data)
  );
  assign w_rd_data = w_hit ? w_hit_data : r_mem[w_idx];
`else
  assign w_wr_en   = w_store;
  assign w_wr_idx  = w_idx;
  assign w_wr_data = store_data;
  assign w_rd_data = r_mem[w_idx];
`endif
  always_ff @(posedge clk)
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  localparam int LAT = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        stall;
  logic        err;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  data_mem_responder #(.WORDS(256), .READ_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (reset && mem_read && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got %08h expected no response", load_data);
      end else chk("load_data", load_data, exp_q.pop_front());
    end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr = a;
    store_data = d;
    model[a[9:2]] = d;
    @(negedge clk);
    chk("store_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic count_stall(input string name);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk(name, n, LAT);
    @(posedge clk);
    #1 mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic with_write);
    exp_q.push_back(model[a[9:2]]);
    mem_read = 1'b1;
    mem_write = with_write;
    store_data = 32'h5555_5555;
    addr = a;
    count_stall("load_stall_cycles");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    mem_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall_gated", {31'd0, stall}, 32'd0);
    chk("rst_load_data0", load_data, 32'd0);
    chk("rst_err0", {31'd0, err}, 32'd0);
    mem_read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 1'b0);
    chk("err_after_basic", {31'd0, err}, 32'd0);
    store(32'h20, 32'h1);
    load(32'h20, 1'b0);
    store(32'h0, 32'hA0A0_0000);
    store(32'h4, 32'hA4A4_0004);
    store(32'h8, 32'hA8A8_0008);
    load(32'h0, 1'b0);
    load(32'h4, 1'b0);
    load(32'h8, 1'b0);
    chk("err_clean", {31'd0, err}, 32'd0);
    load(32'h3, 1'b0);
    chk("err_misaligned", {31'd0, err}, 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    load(32'h8, 1'b1);
    chk("err_rd_wr", {31'd0, err}, 32'd1);
    load(32'h8, 1'b0);
    do_reset();
    exp_q.push_back(model[8'h04]);
    mem_read = 1'b1;
    addr = 32'h10;
    @(posedge clk);
    #1 chk("in_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1 chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    count_stall("reload_stall_cycles");
    store(32'h400, 32'h1234_5678);
    load(32'h0, 1'b0);
    load(32'h400, 1'b0);
    chk("final_err", {31'd0, err}, 32'd0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined MIPS core. It answers word load/store requests issued by the pipeline's memory/writeback stage. Loads have a configurable multi-cycle latency and a stall back-pressure signal. Stores are optionally posted through a one-entry write buffer. It is the memory-side end of the MemRead/MemWrite/address/store-data interface the core drives.

## Interface
- WORDS, 256, array depth in 32-bit words; power of two
- READ_LATENCY, 2, load stall cycles; must be ≥1
- clk  input  1  rising-edge clock (single clock domain)
- reset  input  1  asynchronous, active-low reset
- mem_read  input  1  load request; held until stall low
- mem_write  input  1  store request
- addr  input  32  byte address; word index = addr[log2(WORDS)+1:2], upper bits ignored (wrap)
- store_data  input  32  store data
- load_data  output  32  registered load result
- stall  output  1  pipeline must hold request and all stage registers
- err  output  1  sticky protocol error flag

## Operation
- FSM states: IDLE, WAIT, RESP; all in dmem_pkg enum.
- IDLE:
  - mem_read=1 → load accepted (cycle 0).
  - Next state is RESP if READ_LATENCY=1, else WAIT.
  - A cycle counter is loaded with the remaining wait.
- WAIT: counter decrements each cycle. The FSM enters RESP so that stall is high in exactly cycles 0..READ_LATENCY-1.
- RESP:
  - load_data is valid and stall=0.
  - Next state is IDLE.
  - A new load in the following cycle is accepted normally.
- stall = mem_read & (state != RESP). Stores never stall.
- load_data is captured at the edge entering RESP and holds its value until the next load completes.
- Load source priority when sampled: write-buffer entry with matching word index, else array.
- Store, buffer compiled in: captured into the buffer (valid, index, data) at the edge.
  - If the buffer already held an entry, the old entry is written to the array at the same edge.
  - The buffer otherwise drains to the array at the first edge where it is valid and no new store is captured.
- mem_read and mem_write high together: treated as a load, store ignored, err set.
- addr[1:0]≠0 on any request: err set; the access proceeds with bits [1:0] ignored.
- err clears only on reset.
- Array contents are not reset. The buffer valid bit is reset, so a pending store is discarded by reset.

## Timing
- Reset values (async, while reset=0): state=IDLE, load_data=0, stall=0, err=0, buffer invalid.
- Reset asserted mid-load: load aborted. After release, the FSM is in IDLE; a still-asserted mem_read is re-accepted as a new load.
- Load latency: request in cycle 0, data valid in cycle READ_LATENCY. Total stall = READ_LATENCY cycles.
- Store latency: zero stall; visible to loads from the next cycle onward (via buffer forwarding or the array).
- Back-to-back store then load of the same address: the load returns the stored value.
- The core must keep mem_read, addr and store_data stable while stall=1. A request change during stall is unsupported (err not required).

## Configuration
- DMEM_WRITE_BUFFER_EN defined: one-entry posted write buffer with load forwarding, as above.
- Undefined: no buffer; stores write the array directly at the accepting edge. Forwarding logic is absent; behaviour is otherwise identical, including zero store stall.

## Structure
- dmem_pkg holds:
  - state enum (IDLE/WAIT/RESP)
  - default WORDS and READ_LATENCY constants
  - counter width function clog2
- One sub-module: dmem_write_buffer, holding the entry registers, match compare and drain-enable. It is instantiated only under DMEM_WRITE_BUFFER_EN.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10 with READ_LATENCY=2 → stall high 2 cycles, load_data=0xDEADBEEF in cycle 2, err=0.
- Store 0x1 to 0x20, then immediately load 0x20 (buffer enabled) → 0x1 returned. Same test with the macro undefined → 0x1.
- Three consecutive stores to 0x0/0x4/0x8, then loads of each → 0x0, 0x4, 0x8 contents correct; stall never asserted during stores.
- Load of addr 0x3 → err=1 and data of word 0. Separately, assert mem_read and mem_write together → err=1, array unchanged.
- Assert reset for one cycle during WAIT → stall=0, load_data=0 immediately. After release, the held load completes READ_LATENCY cycles later with correct data.
- Address 0x400 with WORDS=256 → aliases word 0. A store to 0x400 is read back at 0x0.
